// File: rtl/mult4u_mac_accum.sv
// ---------------------------------------------------------------------------
// mult4u_mac_accum
//
// Multiply-accumulate over groups of LEN unsigned 4x4 operand pairs.
// Each accepted pair is registered in operand stage S1. The S1 product is
// added into the accumulator one cycle later. When the last pair of a group
// has been added, the result is held on out_acc/out_ovf with out_valid=1
// until the downstream takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. valid never depends on ready. Once out_valid rises, it and the
// data it qualifies stay stable until the transfer.
//
// Parameters
//   LEN    operand pairs per result (>= 1)
//   ACC_W  accumulator / result width (>= 8)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   pair accepted this cycle when in_valid=1
//   in_a       unsigned multiplicand [3:0]
//   in_b       unsigned multiplier   [3:0]
//   out_valid  group result valid
//   out_ready  downstream accepts the result
//   out_acc    sum of the LEN products [ACC_W-1:0]
//   out_ovf    some addition in the group carried out of ACC_W bits
//
// Build option
//   MULT4U_MAC_SAT_EN  when defined, an overflowing addition saturates the
//                      accumulator to all-ones for the rest of the group.
//                      Otherwise the accumulator wraps. out_ovf is set in
//                      both builds.
// ---------------------------------------------------------------------------

// 4x4 unsigned multiplier. Radix-4 Booth partial products are summed with an
// 8-bit Brent-Kung prefix adder. Purely combinational.
module mult4u_booth4_brentkung (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    // Brent-Kung prefix adder, modulo 2^8. No carry-out is needed, so only
    // the group generates up to bit 6 are built.
    function automatic logic [7:0] bk_add8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] hp;
        logic [6:0] gg;
        logic [6:0] pk;
        hp = x ^ y;
        gg = x[6:0] & y[6:0];
        pk = hp[6:0];
        // up-sweep
        gg[1] = gg[1] | (pk[1] & gg[0]);  pk[1] = pk[1] & pk[0];
        gg[3] = gg[3] | (pk[3] & gg[2]);  pk[3] = pk[3] & pk[2];
        gg[5] = gg[5] | (pk[5] & gg[4]);  pk[5] = pk[5] & pk[4];
        gg[3] = gg[3] | (pk[3] & gg[1]);
        // down-sweep
        gg[5] = gg[5] | (pk[5] & gg[3]);
        gg[2] = gg[2] | (pk[2] & gg[1]);
        gg[4] = gg[4] | (pk[4] & gg[3]);
        gg[6] = gg[6] | (pk[6] & gg[5]);
        return hp ^ {gg, 1'b0};
    endfunction

    // Multiplier is zero-extended to 6 bits so the top digit never goes
    // negative, with an implicit 0 below bit 0 for the first Booth triplet.
    logic [6:0] b_ext;
    logic [7:0] pp [3];
    logic [7:0] corr;
    logic [7:0] sum01;
    logic [7:0] sum2c;

    assign b_ext = {2'b00, b, 1'b0};

    always_comb begin
        corr = '0;
        for (int i = 0; i < 3; i++) begin
            logic [2:0] trip;
            logic       neg;
            logic       one;
            logic       two;
            logic [4:0] mag;
            logic [7:0] row;
            trip = b_ext[2*i+2 -: 3];
            neg  = trip[2];
            one  = trip[1] ^ trip[0];
            two  = (trip == 3'b100) || (trip == 3'b011);
            mag  = two ? {a, 1'b0} : (one ? {1'b0, a} : 5'd0);
            // Negative digits use one's complement here; the +1 goes into corr.
            row  = neg ? ~{3'b000, mag} : {3'b000, mag};
            pp[i] = row << (2 * i);
            corr[2*i] = neg;
        end
    end

    assign sum01 = bk_add8(pp[0], pp[1]);
    assign sum2c = bk_add8(pp[2], corr);
    assign p     = bk_add8(sum01, sum2c);
endmodule

module mult4u_mac_accum #(
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [3:0]       s1_a;
    logic [3:0]       s1_b;
    logic             s1_valid;
    logic             s1_last;
    logic [7:0]       product;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             accept;
    logic             consume;
    logic [ACC_W:0]   sum;

    mult4u_booth4_brentkung u_mult (
        .a (s1_a),
        .b (s1_b),
        .p (product)
    );

    // While the last pair of a group sits in S1, the next group waits. This
    // gap plus the HOLD cycle makes the two-cycle bubble between groups.
    assign in_ready = (state == ACCUM) && !(s1_valid && s1_last);
    assign accept   = in_valid && in_ready;
    assign consume  = (state == ACCUM) && s1_valid;
    assign sum      = {1'b0, acc} + {{(ACC_W-7){1'b0}}, product};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (consume && s1_last) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Operand stage and group counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else if (accept) begin
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_valid <= 1'b1;
            s1_last  <= (count == LAST);
            count    <= (count == LAST) ? '0 : count + 1'b1;
        end else if (consume) begin
            s1_valid <= 1'b0;
        end
    end

    // Accumulator and sticky overflow, cleared when the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                acc <= '0;
                ovf <= 1'b0;
            end
        end else if (consume) begin
`ifdef MULT4U_MAC_SAT_EN
            acc <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
            acc <= sum[ACC_W-1:0];
`endif
            if (sum[ACC_W]) ovf <= 1'b1;
        end
    end

    assign out_valid = (state == HOLD);
    assign out_acc   = acc;
    assign out_ovf   = ovf;
endmodule

// File: doc/mult4u_mac_accum.md
MULT4U_MAC_ACCUM -- requirements
Module: mult4u_mac_accum

Interface
REQ-001 Parameter LEN, default 4, is the number of operand pairs per accumulated result (LEN >= 1).
REQ-002 Parameter ACC_W, default 10, is the accumulator and result width in bits (ACC_W >= 8).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts the pair this cycle.
REQ-007 in_a  input  4  unsigned multiplicand.
REQ-008 in_b  input  4  unsigned multiplier.
REQ-009 out_valid  output  1  group result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_acc  output  ACC_W  sum of LEN products.
REQ-012 out_ovf  output  1  an addition in the group exceeded ACC_W bits.

Function
REQ-013 The block SHALL accept a pair on any rising edge with in_valid=1 and in_ready=1, and none otherwise.
REQ-014 An accepted pair SHALL go to operand stage S1 (s1_a, s1_b, s1_valid, s1_last); s1_last=1 when the group count equals LEN-1 at acceptance.
REQ-015 The S1 product SHALL come from one instance of mult4u_booth4_brentkung (8-bit unsigned, combinational).
REQ-016 The group count SHALL increment on each acceptance and wrap to 0 after LEN-1.
REQ-017 FSM states: ACCUM and HOLD.
REQ-018 In ACCUM with s1_valid=1, acc SHALL become acc + product, zero-extended to ACC_W+1 bits, then truncated to ACC_W. s1_valid SHALL clear unless a new pair is accepted on the same edge.
REQ-019 If that S1 entry has s1_last=1, the FSM SHALL go to HOLD on the same edge with out_valid=1.
REQ-020 out_ovf SHALL be sticky per group and set when any group addition carries out of bit ACC_W-1.
REQ-021 in_ready SHALL be 1 only in ACCUM and only when not (s1_valid and s1_last).
REQ-022 In HOLD, out_valid SHALL stay 1 with out_acc and out_ovf stable until an edge with out_ready=1.
REQ-023 On that edge the FSM SHALL return to ACCUM, clear out_valid, and clear acc and out_ovf.
REQ-024 Latency: out_valid SHALL assert on the edge one cycle after the edge that accepts the last pair.
REQ-025 Throughput: one pair per cycle within a group, with gaps on in_valid allowed. Between groups with out_ready=1, in_ready SHALL be low for exactly 2 cycles.
REQ-026 out_acc SHALL equal acc, which reads 0 outside HOLD after clearing.

Reset
REQ-027 While rst_n=0, the block SHALL force: state ACCUM, count 0, s1_valid 0, acc 0, out_valid 0, out_acc 0, out_ovf 0.
REQ-028 in_ready SHALL be 1 during and after reset.
REQ-029 Reset mid-group or in HOLD SHALL discard the partial or pending result.

Configuration
REQ-030 With macro MULT4U_MAC_SAT_EN defined, an overflowing addition SHALL set acc to all-ones (2^ACC_W-1), hold it for the rest of the group, and set out_ovf.
REQ-031 Without MULT4U_MAC_SAT_EN, acc SHALL wrap modulo 2^ACC_W, and out_ovf SHALL still be set.

Verification
REQ-032 Defaults, out_ready=1, pairs (3,5),(15,15),(0,9),(7,2) -> out_acc=254, out_ovf=0, out_valid one cycle after the 4th acceptance.
REQ-033 Hold out_ready=0 for 3 cycles in HOLD -> out_valid=1, out_acc=254 stable, in_ready=0, no acceptance.
REQ-034 LEN=8, eight pairs (15,15) -> without macro out_acc=776, out_ovf=1; with MULT4U_MAC_SAT_EN out_acc=1023, out_ovf=1.
REQ-035 Two groups back-to-back with in_valid=1 and out_ready=1 -> in_ready low exactly 2 cycles between groups; second group of (1,1) x4 -> out_acc=4.
REQ-036 rst_n low after 2 accepted pairs, then a full group (2,2) x4 -> out_acc=16, with no contribution from the pre-reset pairs.
REQ-037 in_valid toggled every other cycle with pairs (1,15) x4 -> out_acc=60; the count is unaffected by the gaps.
